// File: rtl/batalha_pkg.sv
// batalha_pkg: shared definitions for the attack-phase shot resolver.
// Ship record layout, ship types, result codes and the part-count helper.
package batalha_pkg;

  localparam int NUM_EMB    = 11;
  localparam int ADDR_W     = 5;
  localparam int COORD_W    = 4;
  localparam int GRID_MAX   = 9;
  localparam int REC_W      = 64;
  localparam int COUNT_MSB  = 46;
  localparam int MASK_LSB   = 47;
  localparam int MAX_PARTES = 5;

  typedef enum logic [2:0] {
    PORTA_AVIOES = 3'd0,
    ENCOURACADO  = 3'd1,
    CRUZADOR     = 3'd2,
    DESTROYER    = 3'd3,
    SUBMARINO    = 3'd4
  } tipo_t;

  localparam logic [2:0] RES_AGUA     = 3'd0;
  localparam logic [2:0] RES_ACERTO   = 3'd1;
  localparam logic [2:0] RES_AFUNDOU  = 3'd2;
  localparam logic [2:0] RES_REPETIDO = 3'd3;
  localparam logic [2:0] RES_INVALIDO = 3'd4;

  // Number of part slots a ship type occupies; 0 for unknown types.
  function automatic logic [2:0] num_partes(input logic [2:0] tipo);
    logic [2:0] n;
    unique case (tipo)
      PORTA_AVIOES: n = 3'd5;
      ENCOURACADO:  n = 3'd4;
      CRUZADOR:     n = 3'd3;
      DESTROYER:    n = 3'd2;
      SUBMARINO:    n = 3'd1;
      default:      n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tiro_comparador.sv
// tiro_comparador: matches one shot against the in-use parts of a record.
// Skips unknown types and empty slots; the lowest part index wins.
module tiro_comparador
  import batalha_pkg::*;
(
  input  logic [REC_W-1:0]   registro,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               match,
  output logic [2:0]         match_idx,
  output logic               already_hit
);

  logic [2:0]            tipo;
  logic [3:0]            restantes;
  logic [MAX_PARTES-1:0] mascara;
  logic [2:0]            partes;
  logic                  valido;

  assign tipo      = registro[2:0];
  assign restantes = registro[COUNT_MSB -: 4];
  assign mascara   = registro[MASK_LSB +: MAX_PARTES];
  assign partes    = num_partes(tipo);
  assign valido    = (tipo <= SUBMARINO) &&
                     !(restantes == '0 && mascara == '0);

  // Scan from the top index down so the lowest match is kept.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = MAX_PARTES - 1; i >= 0; i--) begin
      if (valido && (3'(i) < partes) &&
          registro[6+8*i -: COORD_W] == x &&
          registro[10+8*i -: COORD_W] == y) begin
        match     = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  assign already_hit = mascara[match_idx];

endmodule

// File: rtl/resolvedor_tiro.sv
// resolvedor_tiro: resolves a shot against the target's ship records.
// Optional statistics ports are enabled by defining TIRO_ESTAT_EN.
module resolvedor_tiro
  import batalha_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x_tiro,
  input  logic [COORD_W-1:0] y_tiro,
  input  logic               jogador,
  input  logic [REC_W-1:0]   vetor_leitura,
  output logic               mem_sel,
  output logic [ADDR_W-1:0]  read_addr,
  output logic [ADDR_W-1:0]  write_addr,
  output logic [REC_W-1:0]   vetor,
  output logic               wrep1,
  output logic               wrep2,
  output logic               busy,
  output logic               ready,
  output logic [2:0]         resultado,
  output logic [2:0]         tipo_atingido,
  output logic               fim_p1,
  output logic               fim_p2
`ifdef TIRO_ESTAT_EN
  ,
  output logic [7:0]         tiros_p1,
  output logic [7:0]         tiros_p2,
  output logic [7:0]         acertos_p1,
  output logic [7:0]         acertos_p2
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_EMB - 1);
  localparam logic [COORD_W-1:0] GMAX      = COORD_W'(GRID_MAX);
  localparam logic [3:0]         SUNK_LAST = 4'(NUM_EMB - 1);

  logic [2:0]         state;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               jog_q;
  logic [2:0]         res_q;
  logic [2:0]         tipo_q;
  logic [3:0]         sunk_p1;
  logic [3:0]         sunk_p2;

  logic               match;
  logic [2:0]         match_idx;
  logic               already_hit;
  logic               fim_alvo;
  logic               fora;
  logic [REC_W-1:0]   atualizado;
  logic [MAX_PARTES-1:0] bit_novo;

  tiro_comparador u_cmp (
    .registro    (vetor_leitura),
    .x           (x_q),
    .y           (y_q),
    .match       (match),
    .match_idx   (match_idx),
    .already_hit (already_hit)
  );

  assign fim_alvo = jogador ? fim_p1 : fim_p2;
  assign fora     = (x_tiro > GMAX) || (y_tiro > GMAX);

  // Record with the new hit marked and one fewer remaining part.
  always_comb begin
    bit_novo   = MAX_PARTES'(1) << match_idx;
    atualizado = vetor_leitura;
    atualizado[MASK_LSB +: MAX_PARTES] =
      vetor_leitura[MASK_LSB +: MAX_PARTES] | bit_novo;
    atualizado[COUNT_MSB -: 4] =
      vetor_leitura[COUNT_MSB -: 4] - 4'd1;
  end

  // Shot sequencer: scan records, write back hits, track sinkings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      jog_q      <= 1'b0;
      mem_sel    <= 1'b0;
      read_addr  <= '0;
      write_addr <= '0;
      vetor      <= '0;
      res_q      <= RES_AGUA;
      tipo_q     <= '0;
      sunk_p1    <= '0;
      sunk_p2    <= '0;
      fim_p1     <= 1'b0;
      fim_p2     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_q     <= x_tiro;
            y_q     <= y_tiro;
            jog_q   <= jogador;
            mem_sel <= ~jogador;
            tipo_q  <= '0;
            if (fora || fim_alvo) begin
              res_q <= RES_INVALIDO;
              state <= S_DONE;
            end else begin
              read_addr <= '0;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: state <= S_CHECK;
        S_CHECK: begin
          if (match && already_hit) begin
            res_q <= RES_REPETIDO;
            state <= S_DONE;
          end else if (match) begin
            write_addr <= read_addr;
            vetor      <= atualizado;
            tipo_q     <= vetor_leitura[2:0];
            state      <= S_WRITE;
          end else if (read_addr == LAST_ADDR) begin
            res_q <= RES_AGUA;
            state <= S_DONE;
          end else begin
            read_addr <= read_addr + 5'd1;
            state     <= S_FETCH;
          end
        end
        S_WRITE: begin
          if (vetor[COUNT_MSB -: 4] == '0) begin
            res_q <= RES_AFUNDOU;
            if (jog_q) begin
              sunk_p1 <= sunk_p1 + 4'd1;
              if (sunk_p1 == SUNK_LAST) fim_p1 <= 1'b1;
            end else begin
              sunk_p2 <= sunk_p2 + 4'd1;
              if (sunk_p2 == SUNK_LAST) fim_p2 <= 1'b1;
            end
          end else begin
            res_q <= RES_ACERTO;
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign ready         = (state == S_DONE);
  assign resultado     = ready ? res_q : RES_AGUA;
  assign tipo_atingido = ready ? tipo_q : 3'd0;
  assign wrep1         = (state == S_WRITE) && jog_q;
  assign wrep2         = (state == S_WRITE) && !jog_q;

`ifdef TIRO_ESTAT_EN
  logic acerto;
  assign acerto = (res_q == RES_ACERTO) || (res_q == RES_AFUNDOU);

  // Per-attacker shot and hit counters, saturating, bumped on DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tiros_p1   <= '0;
      tiros_p2   <= '0;
      acertos_p1 <= '0;
      acertos_p2 <= '0;
    end else if (state == S_DONE) begin
      if (!jog_q) begin
        if (tiros_p1 != 8'hFF) tiros_p1 <= tiros_p1 + 8'd1;
        if (acerto && acertos_p1 != 8'hFF)
          acertos_p1 <= acertos_p1 + 8'd1;
      end else begin
        if (tiros_p2 != 8'hFF) tiros_p2 <= tiros_p2 + 8'd1;
        if (acerto && acertos_p2 != 8'hFF)
          acertos_p2 <= acertos_p2 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_resolvedor_tiro.sv
// tb_resolvedor_tiro: fleet-level model of the shot resolver.
// Directed scenarios plus randomized shots against both players.
`timescale 1ns/1ps
module tb_resolvedor_tiro;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  x_tiro = '0;
  logic [3:0]  y_tiro = '0;
  logic        jogador = 1'b0;
  logic [63:0] vetor_leitura = '0;
  logic        mem_sel;
  logic [4:0]  read_addr;
  logic [4:0]  write_addr;
  logic [63:0] vetor;
  logic        wrep1, wrep2, busy, ready;
  logic [2:0]  resultado, tipo_atingido;
  logic        fim_p1, fim_p2;
`ifdef TIRO_ESTAT_EN
  logic [7:0]  tiros_p1, tiros_p2, acertos_p1, acertos_p2;
`endif

  resolvedor_tiro dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .x_tiro        (x_tiro),
    .y_tiro        (y_tiro),
    .jogador       (jogador),
    .vetor_leitura (vetor_leitura),
    .mem_sel       (mem_sel),
    .read_addr     (read_addr),
    .write_addr    (write_addr),
    .vetor         (vetor),
    .wrep1         (wrep1),
    .wrep2         (wrep2),
    .busy          (busy),
    .ready         (ready),
    .resultado     (resultado),
    .tipo_atingido (tipo_atingido),
    .fim_p1        (fim_p1),
    .fim_p2        (fim_p2)
`ifdef TIRO_ESTAT_EN
    ,
    .tiros_p1      (tiros_p1),
    .tiros_p2      (tiros_p2),
    .acertos_p1    (acertos_p1),
    .acertos_p2    (acertos_p2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Player memories: index 0 = P1, 1 = P2; 1-cycle read latency.
  logic [63:0] mem [2][11];
  always @(posedge clk) begin
    if (read_addr < 5'd11)
      vetor_leitura <= mem[mem_sel][read_addr];
    else
      vetor_leitura <= '0;
    if (wrep1 && write_addr < 5'd11) mem[0][write_addr] = vetor;
    if (wrep2 && write_addr < 5'd11) mem[1][write_addr] = vetor;
  end

  // Fleet model: ships as coordinate lists with per-part hit flags.
  int          s_tipo [2][11];
  int          s_x    [2][11][5];
  int          s_y    [2][11][5];
  bit          s_hit  [2][11][5];
  bit          s_empty[2][11];
  logic [11:0] s_hi   [2][11];
  int          m_sunk [2];
  bit          m_fim  [2];

  int n_chk = 0;
  int n_err = 0;

  int          e_res, e_lat, e_tipo, e_waddr;
  logic [1:0]  e_wsel;
  logic [63:0] e_wdata;
  bit          w_pend = 0;
  bit          r_pend = 0;
  int          t0 = 0;
  int          n_ready = 0;
  logic [63:0] last_wdata = '0;
  int          last_lat = 0, last_res = 0, last_tipo = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] encode(input int p, input int k);
    logic [63:0] r;
    int h;
    int t;
    r = '0;
    h = 0;
    t = s_tipo[p][k];
    r[2:0] = 3'(t);
    for (int i = 0; i < 5; i++) begin
      r[6+8*i -: 4]  = 4'(s_x[p][k][i]);
      r[10+8*i -: 4] = 4'(s_y[p][k][i]);
      r[47+i] = s_hit[p][k][i];
      if (s_hit[p][k][i]) h++;
    end
    if (s_empty[p][k]) r[46:43] = 4'd0;
    else if (t > 4) r[46:43] = 4'd3;
    else r[46:43] = 4'(5 - t - h);
    r[63:52] = s_hi[p][k];
    return r;
  endfunction

  // Decide the outcome from the fleet, then drive the request.
  task automatic shot(input int x, input int y, input bit j,
                      input bit poke);
    int p, fk, fi, n, h;
    bit found;
    p = j ? 0 : 1;
    e_tipo = 0;
    e_waddr = 0;
    e_wsel = 2'b00;
    e_wdata = '0;
    fk = 0;
    fi = 0;
    found = 0;
    w_pend = 0;
    if (x > 9 || y > 9 || m_fim[p]) begin
      e_res = 4;
      e_lat = 1;
    end else begin
      for (int k = 0; k < 11; k++) begin
        if (!found && !s_empty[p][k] && s_tipo[p][k] <= 4) begin
          n = 5 - s_tipo[p][k];
          for (int i = 0; i < n; i++)
            if (!found && s_x[p][k][i] == x && s_y[p][k][i] == y) begin
              found = 1;
              fk = k;
              fi = i;
            end
        end
      end
      if (!found) begin
        e_res = 0;
        e_lat = 23;
      end else if (s_hit[p][fk][fi]) begin
        e_res = 3;
        e_lat = 2 * fk + 3;
      end else begin
        s_hit[p][fk][fi] = 1;
        e_waddr = fk;
        e_wsel = (p == 0) ? 2'b10 : 2'b01;
        e_wdata = encode(p, fk);
        e_tipo = s_tipo[p][fk];
        e_lat = 2 * fk + 4;
        n = 5 - s_tipo[p][fk];
        h = 0;
        for (int i = 0; i < n; i++) if (s_hit[p][fk][i]) h++;
        if (h == n) begin
          e_res = 2;
          m_sunk[p]++;
          if (m_sunk[p] == 11) m_fim[p] = 1;
        end else begin
          e_res = 1;
        end
        w_pend = 1;
      end
    end
    @(posedge clk); #1;
    x_tiro = 4'(x);
    y_tiro = 4'(y);
    jogador = j;
    start = 1'b1;
    t0 = cyc;
    r_pend = 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      x_tiro = 4'd1;
      y_tiro = 4'd1;
      jogador = ~j;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < 60 && r_pend; c++) @(negedge clk);
    if (r_pend) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: no ready after shot (%0d,%0d)", x, y);
      r_pend = 0;
      w_pend = 0;
    end
  endtask

  // Single compare process: write-back and result checks each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wrep1 || wrep2) begin
        last_wdata = vetor;
        if (!w_pend) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: got %b expected none",
                   {wrep1, wrep2});
        end else begin
          chk("wr_sel", 64'({wrep1, wrep2}), 64'(e_wsel));
          chk("wr_addr", 64'(write_addr), 64'(e_waddr));
          chk("wr_data", vetor, e_wdata);
          w_pend = 0;
        end
      end
      if (ready) begin
        n_ready++;
        last_lat = cyc - t0;
        last_res = int'(resultado);
        last_tipo = int'(tipo_atingido);
        if (!r_pend) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_ready: got res %0d expected none",
                   resultado);
        end else begin
          chk("res", 64'(resultado), 64'(e_res));
          chk("latency", 64'(last_lat), 64'(e_lat));
          if (e_res != 3)
            chk("tipo", 64'(tipo_atingido), 64'(e_tipo));
          chk("fim_p1", 64'(fim_p1), 64'(m_fim[0]));
          chk("fim_p2", 64'(fim_p2), 64'(m_fim[1]));
          chk("write_seen", 64'(w_pend), 64'(0));
          r_pend = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int dt[11] = '{0, 1, 1, 2, 2, 3, 3, 3, 4, 4, 4};
  int dx[11] = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 7};
  int dy[11] = '{3, 0, 1, 2, 4, 5, 6, 8, 9, 9, 7};

  initial begin
    int ra, nr, r, t, n, x0, y0, sx, sy;
    bit vert, sj;
    // P2: directed fleet, unused part slots parked on (9,9).
    for (int k = 0; k < 11; k++) begin
      s_tipo[1][k] = dt[k];
      s_empty[1][k] = 0;
      s_hi[1][k] = 12'($urandom);
      for (int i = 0; i < 5; i++) begin
        s_hit[1][k][i] = 0;
        if (i < 5 - dt[k]) begin
          s_x[1][k][i] = dx[k] + i;
          s_y[1][k][i] = dy[k];
        end else begin
          s_x[1][k][i] = 9;
          s_y[1][k][i] = 9;
        end
      end
    end
    // P1: random fleet with empty slots and unknown-type records.
    for (int k = 0; k < 11; k++) begin
      s_hi[0][k] = 12'($urandom);
      for (int i = 0; i < 5; i++) begin
        s_x[0][k][i] = $urandom_range(0, 15);
        s_y[0][k][i] = $urandom_range(0, 15);
        s_hit[0][k][i] = 0;
      end
      r = $urandom_range(0, 9);
      s_empty[0][k] = (r == 0);
      if (r == 1) begin
        s_tipo[0][k] = $urandom_range(5, 7);
      end else begin
        t = $urandom_range(0, 4);
        s_tipo[0][k] = t;
        n = 5 - t;
        vert = 1'($urandom_range(0, 1));
        x0 = vert ? $urandom_range(0, 9) : $urandom_range(0, 10 - n);
        y0 = vert ? $urandom_range(0, 10 - n) : $urandom_range(0, 9);
        for (int i = 0; i < n; i++) begin
          s_x[0][k][i] = vert ? x0 : x0 + i;
          s_y[0][k][i] = vert ? y0 + i : y0;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      m_sunk[p] = 0;
      m_fim[p] = 0;
      for (int k = 0; k < 11; k++) mem[p][k] = encode(p, k);
    end

    // Reset values.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_res", 64'(resultado), 64'(0));
    chk("rst_tipo", 64'(tipo_atingido), 64'(0));
    chk("rst_raddr", 64'(read_addr), 64'(0));
    chk("rst_waddr", 64'(write_addr), 64'(0));
    chk("rst_vetor", vetor, 64'(0));
    chk("rst_wrep", 64'({wrep1, wrep2}), 64'(0));
    chk("rst_fim", 64'({fim_p1, fim_p2}), 64'(0));
    chk("rst_memsel", 64'(mem_sel), 64'(0));

    // Reset in the middle of FETCH aborts with no write.
    @(posedge clk); #1;
    x_tiro = 4'd2; y_tiro = 4'd3; jogador = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy_before", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_wrep", 64'({wrep1, wrep2}), 64'(0));
    chk("abort_memsel", 64'(mem_sel), 64'(0));
    chk("abort_ready", 64'(ready), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_ready", 64'(n_ready), 64'(0));
    chk("abort_mem", mem[1][0], encode(1, 0));

    // Miss scans all records; unused slots at (9,9) are ignored.
    shot(9, 9, 0, 0);
    chk("miss_res_lit", 64'(last_res), 64'(0));
    chk("miss_lat_lit", 64'(last_lat), 64'(23));

    // Invalid coordinates: one-cycle answer, no memory access.
    ra = int'(read_addr);
    shot(10, 2, 0, 0);
    chk("inv_res_lit", 64'(last_res), 64'(4));
    chk("inv_lat_lit", 64'(last_lat), 64'(1));
    chk("inv_raddr", 64'(read_addr), 64'(ra));
    shot(2, 10, 1, 0);
    chk("inv_y_res_lit", 64'(last_res), 64'(4));

    // Hit on record 0, part 2.
    shot(4, 3, 0, 0);
    chk("hit_res_lit", 64'(last_res), 64'(1));
    chk("hit_lat_lit", 64'(last_lat), 64'(4));
    chk("hit_mask_lit", 64'(last_wdata[49]), 64'(1));
    chk("hit_count_lit", 64'(last_wdata[46:43]), 64'(4));

    // Same cell again.
    shot(4, 3, 0, 0);
    chk("rep_res_lit", 64'(last_res), 64'(3));
    chk("rep_lat_lit", 64'(last_lat), 64'(3));

    // A start pulse while busy is dropped.
    nr = n_ready;
    shot(9, 8, 0, 1);
    repeat (30) @(negedge clk);
    chk("busy_ignore", 64'(n_ready - nr), 64'(1));

    // Random shots at both players; (7,7) on P2 kept for the finale.
    for (int s = 0; s < 150; s++) begin
      sj = 1'($urandom_range(0, 1));
      sx = $urandom_range(0, 10);
      sy = $urandom_range(0, 10);
      if (!sj && sx == 7 && sy == 7) sx = 8;
      shot(sx, sy, sj, 0);
    end

    // Sink every P2 ship, submarine at record 10 last.
    for (int k = 0; k < 11; k++)
      for (int i = 0; i < 5 - dt[k]; i++)
        shot(s_x[1][k][i], s_y[1][k][i], 0, 0);
    chk("sink_res_lit", 64'(last_res), 64'(2));
    chk("sink_tipo_lit", 64'(last_tipo), 64'(4));
    chk("sink_lat_lit", 64'(last_lat), 64'(24));
    chk("fim_p2_lit", 64'(fim_p2), 64'(1));

    // Game over for P2: further shots at it are rejected.
    shot(0, 0, 0, 0);
    chk("after_end_lit", 64'(last_res), 64'(4));
    shot(3, 3, 1, 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
